// File: rtl/string_fifo_pkg.sv
// Shared types and constants for the two-channel string FIFO with word-compare engine.
package string_fifo_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA0  = 3'd0,
    ADDR_DATA1  = 3'd1,
    ADDR_STAT0  = 3'd2,
    ADDR_STAT1  = 3'd3,
    ADDR_CTRL   = 3'd4,
    ADDR_RESULT = 3'd5,
    ADDR_RSVD6  = 3'd6,
    ADDR_RSVD7  = 3'd7
  } addr_e;

  typedef enum logic [1:0] {
    ENG_IDLE = 2'd0,
    ENG_CMP  = 2'd1,
    ENG_DONE = 2'd2
  } eng_state_e;

  localparam int unsigned ST_EMPTY_BIT  = 0;
  localparam int unsigned ST_FULL_BIT   = 1;
  localparam int unsigned ST_OVF_BIT    = 2;
  localparam int unsigned ST_UNF_BIT    = 3;
  localparam int unsigned ST_CNT_LSB    = 16;

  localparam int unsigned RES_DONE_BIT  = 0;
  localparam int unsigned RES_EQUAL_BIT = 1;
  localparam int unsigned RES_IDX_LSB   = 8;
  localparam int unsigned RES_CNT_LSB   = 16;

  localparam logic [31:0] EMPTY_WORD    = 32'hDEADDEAD;
  localparam logic [31:0] BUSY_WORD_DEF = 32'hDEADFACE;

  function automatic logic [31:0] fmt_status(input logic [15:0] cnt, input logic unf,
                                             input logic ovf, input logic full,
                                             input logic empty);
    logic [31:0] s;
    s = '0;
    s[ST_CNT_LSB +: 16] = cnt;
    s[ST_UNF_BIT]       = unf;
    s[ST_OVF_BIT]       = ovf;
    s[ST_FULL_BIT]      = full;
    s[ST_EMPTY_BIT]     = empty;
    return s;
  endfunction

endpackage

// File: rtl/string_fifo_ch.sv
// One circular FIFO channel with sticky overflow/underflow flags; storage has no reset.
module string_fifo_ch #(
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned DW    = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  logic          clr_sticky_i,
  input  logic [DW-1:0] din_i,
  output logic [DW-1:0] dout_c,
  output logic [CW-1:0] count_o,
  output logic          full_c,
  output logic          empty_c,
  output logic          ovf_o,
  output logic          unf_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          push_ok_c, pop_ok_c;

  assign full_c    = (count_q == CW'(DEPTH));
  assign empty_c   = (count_q == '0);
  assign push_ok_c = push_i && !full_c && !flush_i;
  assign pop_ok_c  = pop_i && !empty_c && !flush_i;

  // Flush wins over any access in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (push_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok_c)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_ok_c) - CW'(pop_ok_c);
      if (clr_sticky_i) begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
      end
      if (push_i && full_c)  ovf_d = 1'b1;
      if (pop_i  && empty_c) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok_c) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_c  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign ovf_o   = ovf_q;
  assign unf_o   = unf_q;

endmodule

// File: rtl/string_fifo_avalon_mc.sv
// Avalon-MM slave with two word FIFOs and an optional FIFO-compare engine.
// Define STRING_CMP_EN to build the compare engine; otherwise go is ignored.
module string_fifo_avalon_mc
  import string_fifo_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [31:0] BUSY_WORD = BUSY_WORD_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [2:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  addr_e         addr_c;
  logic          rd_c, wr_c, busy_c, eng_pop_c;
  logic [1:0]    push_c, pop_c, flush_c, clr_c, full_c, empty_c, ovf_c, unf_c;
  logic [DW-1:0] dout_c   [2];
  logic [CW-1:0] count_c  [2];
  logic [31:0]   status_c [2];
  logic [31:0]   ctrl_c, result_c, rdata_d, rdata_q;

  assign addr_c = addr_e'(address);
  assign rd_c   = chipselect && read;
  assign wr_c   = chipselect && write;

  for (genvar g = 0; g < 2; g++) begin : g_ch
    localparam addr_e DATA_A = addr_e'(3'(g));
    localparam addr_e STAT_A = addr_e'(3'(g + 2));

    assign push_c[g]  = wr_c && (addr_c == DATA_A) && !busy_c;
    assign pop_c[g]   = (rd_c && (addr_c == DATA_A) && !busy_c) || eng_pop_c;
    assign flush_c[g] = wr_c && (addr_c == STAT_A) && writedata[0];
    assign clr_c[g]   = wr_c && (addr_c == STAT_A) && writedata[1];

    string_fifo_ch #(.DEPTH(DEPTH), .DW(DW)) u_ch (
      .clk          (clk),
      .rst_n        (reset_n),
      .push_i       (push_c[g]),
      .pop_i        (pop_c[g]),
      .flush_i      (flush_c[g]),
      .clr_sticky_i (clr_c[g]),
      .din_i        (writedata),
      .dout_c       (dout_c[g]),
      .count_o      (count_c[g]),
      .full_c       (full_c[g]),
      .empty_c      (empty_c[g]),
      .ovf_o        (ovf_c[g]),
      .unf_o        (unf_c[g])
    );

    assign status_c[g] = fmt_status(16'(count_c[g]), unf_c[g], ovf_c[g], full_c[g], empty_c[g]);
  end

`ifdef STRING_CMP_EN
  eng_state_e    state_q, state_d;
  logic [CW-1:0] cmp_cnt_q, cmp_cnt_d, idx_q, idx_d;
  logic          eq_q, eq_d, done_q, done_d;
  logic          go_c, flush_any_c, last0_c, last1_c;

  assign go_c        = wr_c && (addr_c == ADDR_CTRL) && writedata[0];
  assign flush_any_c = |flush_c;
  assign last0_c     = (count_c[0] == CW'(1));
  assign last1_c     = (count_c[1] == CW'(1));
  assign busy_c      = (state_q == ENG_CMP);

  // Lookahead on count==1 ends CMP on the cycle that drains a FIFO.
  always_comb begin
    state_d   = state_q;
    cmp_cnt_d = cmp_cnt_q;
    idx_d     = idx_q;
    eq_d      = eq_q;
    done_d    = done_q;
    eng_pop_c = 1'b0;
    case (state_q)
      ENG_IDLE: begin
        if (go_c) begin
          state_d   = ENG_CMP;
          cmp_cnt_d = '0;
          idx_d     = '0;
          eq_d      = 1'b0;
          done_d    = 1'b0;
        end
      end
      ENG_CMP: begin
        if (flush_any_c) begin
          state_d = ENG_IDLE;
          done_d  = 1'b0;
        end else if (empty_c[0] || empty_c[1]) begin
          state_d = ENG_DONE;
          done_d  = 1'b1;
          eq_d    = &empty_c;
        end else begin
          eng_pop_c = 1'b1;
          cmp_cnt_d = cmp_cnt_q + CW'(1);
          if (dout_c[0] != dout_c[1]) begin
            state_d = ENG_DONE;
            done_d  = 1'b1;
            eq_d    = 1'b0;
            idx_d   = cmp_cnt_q;
          end else if (last0_c || last1_c) begin
            state_d = ENG_DONE;
            done_d  = 1'b1;
            eq_d    = last0_c && last1_c;
          end
        end
      end
      ENG_DONE: state_d = ENG_IDLE;
      default:  state_d = ENG_IDLE;
    endcase
    if (flush_any_c && (state_q != ENG_CMP)) done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ENG_IDLE;
      cmp_cnt_q <= '0;
      idx_q     <= '0;
      eq_q      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmp_cnt_q <= cmp_cnt_d;
      idx_q     <= idx_d;
      eq_q      <= eq_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    result_c                      = '0;
    result_c[RES_CNT_LSB +: 16]   = 16'(cmp_cnt_q);
    result_c[RES_IDX_LSB +: 8]    = 8'(idx_q);
    result_c[RES_EQUAL_BIT]       = eq_q;
    result_c[RES_DONE_BIT]        = done_q;
  end
  assign ctrl_c = 32'(busy_c);
`else
  assign busy_c    = 1'b0;
  assign eng_pop_c = 1'b0;
  assign ctrl_c    = '0;
  assign result_c  = '0;
`endif

  // Read mux; readdata holds its value on cycles without a read.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_c) begin
      case (addr_c)
        ADDR_DATA0:  rdata_d = busy_c ? BUSY_WORD : (empty_c[0] ? EMPTY_WORD : dout_c[0]);
        ADDR_DATA1:  rdata_d = busy_c ? BUSY_WORD : (empty_c[1] ? EMPTY_WORD : dout_c[1]);
        ADDR_STAT0:  rdata_d = status_c[0];
        ADDR_STAT1:  rdata_d = status_c[1];
        ADDR_CTRL:   rdata_d = ctrl_c;
        ADDR_RESULT: rdata_d = result_c;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rdata_q <= '0;
    else          rdata_q <= rdata_d;
  end

  assign readdata = rdata_q;

endmodule

// File: tb/tb_string_fifo_avalon_mc.sv
// Scoreboard bench for string_fifo_avalon_mc; expectations follow STRING_CMP_EN when defined.
`timescale 1ns/1ps
module tb_string_fifo_avalon_mc;

`ifdef STRING_CMP_EN
  localparam bit ENG = 1'b1;
`else
  localparam bit ENG = 1'b0;
`endif

  localparam logic [2:0] A_D0 = 3'd0, A_D1 = 3'd1, A_S0 = 3'd2, A_S1 = 3'd3;
  localparam logic [2:0] A_CTRL = 3'd4, A_RES = 3'd5, A_RSV6 = 3'd6, A_RSV7 = 3'd7;
  localparam logic [31:0] WA = 32'hA5A5_0001, WB = 32'hB6B6_0002;
  localparam logic [31:0] WC = 32'hC7C7_0003, WX = 32'h1234_5678;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chipselect = 1'b0, read = 1'b0, write = 1'b0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];
  logic        rd_vld = 1'b0;

  string_fifo_avalon_mc #(.DEPTH(16), .BUSY_WORD(32'hDEADFACE)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .read       (read),
    .write      (write),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
    else n_pass++;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; read = 1'b0; address = a; writedata = d;
    @(posedge clk); #1;
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, input logic [31:0] e, input string tag);
    chipselect = 1'b1; read = 1'b1; write = 1'b0; address = a;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic fill3(input logic [2:0] a, input logic [31:0] w1, input logic [31:0] w2);
    bus_write(a, WA);
    bus_write(a, w1);
    bus_write(a, w2);
  endtask

  // Latency-1 read model: the word appears one clock after the read strobe.
  always @(posedge clk) rd_vld <= chipselect && read;

  always @(negedge clk) begin
    if (rd_vld) begin
      if (exp_q.size() == 0) check_eq("sb_underrun", 32'd1, 32'd0);
      else check_eq(tag_q.pop_front(), readdata, exp_q.pop_front());
    end
  end

  initial begin
    #23 reset_n = 1'b1;
    check_eq("rst_rdata", readdata, 32'h0);
    @(posedge clk); #1;
    bus_read(A_S0, 32'h0000_0001, "rst_stat0");
    bus_read(A_S1, 32'h0000_0001, "rst_stat1");
    bus_read(A_RES, 32'h0, "rst_result");

    // In-order readback with latency 1
    fill3(A_D0, WB, WC);
    bus_read(A_S0, 32'h0003_0000, "t1_stat_cnt3");
    bus_read(A_D0, WA, "t1_rd0");
    bus_read(A_D0, WB, "t1_rd1");
    bus_read(A_D0, WC, "t1_rd2");
    bus_read(A_S0, 32'h0000_0001, "t1_stat_empty");

    // Overflow on ch1: 17th word dropped
    for (int i = 0; i < 17; i++) bus_write(A_D1, 32'h1000_0000 + 32'(i));
    bus_read(A_S1, 32'h0010_0006, "t2_stat_full_ovf");
    for (int i = 0; i < 16; i++) bus_read(A_D1, 32'h1000_0000 + 32'(i), "t2_rd");
    bus_read(A_D1, 32'hDEAD_DEAD, "t2_rd17_absent");
    bus_write(A_S1, 32'h1);
    bus_read(A_S1, 32'h0000_0001, "t2_flush");

    // Underflow and sticky clear
    bus_read(A_D0, 32'hDEAD_DEAD, "t3_rd_empty");
    bus_read(A_S0, 32'h0000_0009, "t3_stat_unf");
    bus_write(A_D0, WX);
    bus_read(A_S0, 32'h0001_0008, "t3_stat_unf_cnt1");
    bus_write(A_S0, 32'h2);
    bus_read(A_S0, 32'h0001_0000, "t3_clr_sticky");
    bus_read(A_RSV6, 32'h0, "t3_rsvd6");
    bus_write(A_RSV7, 32'hFFFF_FFFF);
    bus_write(A_S0, 32'h1);
    bus_read(A_S0, 32'h0000_0001, "t3_flush");

    // Equal strings
    fill3(A_D0, WB, WC);
    fill3(A_D1, WB, WC);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, ENG ? 32'h1 : 32'h0, "t4_busy_c1");
    bus_read(A_CTRL, ENG ? 32'h1 : 32'h0, "t4_busy_c2");
    bus_read(A_CTRL, ENG ? 32'h1 : 32'h0, "t4_busy_c3");
    bus_read(A_CTRL, 32'h0, "t4_busy_c4");
    bus_read(A_RES, ENG ? 32'h0003_0003 : 32'h0, "t4_result");
    bus_read(A_S0, ENG ? 32'h0000_0001 : 32'h0003_0000, "t4_stat0");
    bus_read(A_S1, ENG ? 32'h0000_0001 : 32'h0003_0000, "t4_stat1");
    bus_write(A_S0, 32'h1);
    bus_write(A_S1, 32'h1);

    // Mismatch at index 1; data read while busy
    fill3(A_D0, WX, WC);
    fill3(A_D1, WB, WC);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_D0, ENG ? 32'hDEAD_FACE : WA, "t5_rd_busy");
    bus_read(A_CTRL, ENG ? 32'h1 : 32'h0, "t5_busy");
    bus_read(A_RES, ENG ? 32'h0002_0101 : 32'h0, "t5_result");
    bus_read(A_S0, ENG ? 32'h0001_0000 : 32'h0002_0000, "t5_stat0");
    bus_read(A_S1, ENG ? 32'h0001_0000 : 32'h0003_0000, "t5_stat1");
    bus_write(A_S0, 32'h1);
    bus_write(A_S1, 32'h1);

    // Flush aborts a running compare
    fill3(A_D0, WB, WC);
    fill3(A_D1, WB, WC);
    bus_write(A_CTRL, 32'h1);
    bus_write(A_S0, 32'h1);
    bus_read(A_CTRL, 32'h0, "t6_abort_busy");
    bus_read(A_RES, 32'h0, "t6_abort_result");
    bus_read(A_S0, 32'h0000_0001, "t6_stat0");
    bus_read(A_S1, 32'h0003_0000, "t6_stat1_nopop");

    // Asynchronous reset in the middle of a compare
    fill3(A_D0, WB, WC);
    bus_write(A_CTRL, 32'h1);
    #2 reset_n = 1'b0;
    #1 check_eq("t6_rst_rdata", readdata, 32'h0);
    #10 reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(A_S0, 32'h0000_0001, "t6_rst_stat0");
    bus_read(A_S1, 32'h0000_0001, "t6_rst_stat1");
    bus_read(A_CTRL, 32'h0, "t6_rst_ctrl");
    bus_read(A_RES, 32'h0, "t6_rst_result");

    @(posedge clk); #1;
    @(posedge clk); #1;
    check_eq("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
